// File: rtl/mem_arb_pkg.sv
// Shared types for the instruction/data memory port arbiter.
// States, grant encoding and the full-word byte-enable constant.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY_IF,
    BUSY_DM,
    RESP
  } state_t;

  typedef enum logic {
    GNT_IF,
    GNT_DM
  } grant_t;

  localparam logic [3:0] BE_WORD = 4'hF;

endpackage

// File: rtl/mem_port_arbiter.sv
// Shares one 32-bit memory port between fetch and load/store.
// Data has priority, bounded by a fairness streak; BUSY has a timeout.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter logic [31:0] DATA_ADDR_OR = 32'h8000_0000,
  parameter int          FAIRNESS     = 4,
  parameter int          TIMEOUT      = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_valid,
  output logic [31:0] if_rdata,
  input  logic        dm_req,
  input  logic        dm_we,
  input  logic [31:0] dm_addr,
  input  logic [3:0]  dm_be,
  input  logic [31:0] dm_wdata,
  output logic        dm_valid,
  output logic [31:0] dm_rdata,
  output logic        bus_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready
);

  localparam logic [3:0] FAIR     = 4'(FAIRNESS);
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);
  localparam bit         TMO_EN   = (TIMEOUT != 0);

  state_t      state_q, state_d;
  grant_t      gnt;
  logic [3:0]  streak_q, streak_d;
  logic [7:0]  tmo_q, tmo_d;
  logic        tmo_hit;

  logic        if_valid_d, dm_valid_d, bus_err_d;
  logic        mem_req_d, mem_we_d;
  logic [31:0] if_rdata_d, dm_rdata_d;
  logic [31:0] mem_addr_d, mem_wdata_d;
  logic [3:0]  mem_be_d;

  // fetch only wins a contested slot once data has used its streak
  assign gnt = (dm_req && !(if_req && streak_q == FAIR))
             ? GNT_DM : GNT_IF;

  assign tmo_hit = TMO_EN && (tmo_q == TMO_LAST);

  always_comb begin
    state_d     = state_q;
    streak_d    = streak_q;
    tmo_d       = tmo_q;
    if_valid_d  = 1'b0;
    dm_valid_d  = 1'b0;
    bus_err_d   = 1'b0;
    if_rdata_d  = if_rdata;
    dm_rdata_d  = dm_rdata;
    mem_req_d   = mem_req;
    mem_we_d    = mem_we;
    mem_addr_d  = mem_addr;
    mem_be_d    = mem_be;
    mem_wdata_d = mem_wdata;
    unique case (state_q)
      IDLE: begin
        if (if_req || dm_req) begin
          tmo_d     = '0;
          mem_req_d = 1'b1;
          if (gnt == GNT_DM) begin
            state_d     = BUSY_DM;
            mem_we_d    = dm_we;
            mem_addr_d  = dm_addr | DATA_ADDR_OR;
            mem_be_d    = dm_we ? dm_be : BE_WORD;
            mem_wdata_d = dm_wdata;
            if (!if_req)
              streak_d = '0;
            else if (streak_q != FAIR)
              streak_d = streak_q + 4'd1;
          end else begin
            state_d     = BUSY_IF;
            mem_we_d    = 1'b0;
            mem_addr_d  = if_addr;
            mem_be_d    = BE_WORD;
            mem_wdata_d = '0;
            streak_d    = '0;
          end
        end
      end
      BUSY_IF, BUSY_DM: begin
        if (mem_ready || tmo_hit) begin
          state_d   = RESP;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          bus_err_d = !mem_ready;
          if (state_q == BUSY_IF) begin
            if_valid_d = 1'b1;
            if_rdata_d = mem_ready ? mem_rdata : '0;
          end else begin
            dm_valid_d = 1'b1;
            dm_rdata_d = (mem_ready && !mem_we)
                       ? mem_rdata : '0;
          end
        end else begin
          tmo_d = tmo_q + 8'd1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      streak_q  <= '0;
      tmo_q     <= '0;
      if_valid  <= 1'b0;
      dm_valid  <= 1'b0;
      bus_err   <= 1'b0;
      if_rdata  <= '0;
      dm_rdata  <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_be    <= '0;
      mem_wdata <= '0;
    end else begin
      state_q   <= state_d;
      streak_q  <= streak_d;
      tmo_q     <= tmo_d;
      if_valid  <= if_valid_d;
      dm_valid  <= dm_valid_d;
      bus_err   <= bus_err_d;
      if_rdata  <= if_rdata_d;
      dm_rdata  <= dm_rdata_d;
      mem_req   <= mem_req_d;
      mem_we    <= mem_we_d;
      mem_addr  <= mem_addr_d;
      mem_be    <= mem_be_d;
      mem_wdata <= mem_wdata_d;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Random fetch/load/store traffic against a memory whose latency and
// data are functions of the address; responses checked via scoreboard.
module tb_mem_port_arbiter;

  localparam int          FAIR = 4;
  localparam int          TMO  = 16;
  localparam logic [31:0] DOR  = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req, dm_req, dm_we, mem_ready;
  logic [31:0] if_addr, dm_addr, dm_wdata, mem_rdata;
  logic [3:0]  dm_be;
  logic        if_valid, dm_valid, bus_err, mem_req, mem_we;
  logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata;
  logic [3:0]  mem_be;

  mem_port_arbiter #(
    .DATA_ADDR_OR(DOR),
    .FAIRNESS    (FAIR),
    .TIMEOUT     (TMO)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .if_req   (if_req),
    .if_addr  (if_addr),
    .if_valid (if_valid),
    .if_rdata (if_rdata),
    .dm_req   (dm_req),
    .dm_we    (dm_we),
    .dm_addr  (dm_addr),
    .dm_be    (dm_be),
    .dm_wdata (dm_wdata),
    .dm_valid (dm_valid),
    .dm_rdata (dm_rdata),
    .bus_err  (bus_err),
    .mem_req  (mem_req),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_be   (mem_be),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t if_q[$];
  exp_t dm_q[$];

  int checks    = 0;
  int failures  = 0;
  int fair_hits = 0;
  bit run       = 1'b0;

  // memory behaviour: ready on BUSY cycle lat(a); >TMO means never
  function automatic int lat(input logic [31:0] a);
    return (int'(a[6:2]) % 20) + 1;
  endfunction

  function automatic logic [31:0] hashv(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
  endfunction

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)",
               name, act, exp, $time);
    end
  endtask

  // requester and memory driver, acting just after each rising edge
  bit if_done = 1'b0;
  bit dm_done = 1'b0;
  int mc = 0;

  always @(posedge clk) begin
    #1;
    if (mem_req) begin
      mc++;
      mem_ready = (mc == lat(mem_addr));
      mem_rdata = mem_ready ? hashv(mem_addr) : $urandom;
    end else begin
      mc = 0;
      mem_ready = 1'($urandom_range(0, 1));
      mem_rdata = $urandom;
    end
    if (if_done) begin
      if_req  = 1'b0;
      if_done = 1'b0;
    end
    if (dm_done) begin
      dm_req  = 1'b0;
      dm_done = 1'b0;
    end
    if (if_valid) if_done = 1'b1;
    if (dm_valid) dm_done = 1'b1;
    if (run && reset) begin
      if (!if_req && !if_done && $urandom_range(0, 3) != 0) begin
        exp_t e;
        int   k;
        if_addr = $urandom & 32'hFFFF_FFFC;
        k       = lat(if_addr);
        e.err   = (k > TMO);
        e.rdata = e.err ? 32'h0 : hashv(if_addr);
        if_q.push_back(e);
        if_req = 1'b1;
      end
      if (!dm_req && !dm_done && $urandom_range(0, 7) != 0) begin
        exp_t        e;
        logic [31:0] ma;
        dm_addr  = $urandom;
        dm_we    = 1'($urandom_range(0, 1));
        dm_be    = 4'($urandom_range(0, 15));
        dm_wdata = $urandom;
        ma       = dm_addr | DOR;
        e.err    = (lat(ma) > TMO);
        e.rdata  = (dm_we || e.err) ? 32'h0 : hashv(ma);
        dm_q.push_back(e);
        dm_req = 1'b1;
      end
    end
  end

  // requester inputs as the DUT saw them at the last rising edge
  logic        s_if_req, s_dm_req, s_dm_we;
  logic [31:0] s_if_addr, s_dm_addr, s_dm_wdata;
  logic [3:0]  s_dm_be;

  always @(posedge clk) begin
    s_if_req   = if_req;
    s_if_addr  = if_addr;
    s_dm_req   = dm_req;
    s_dm_we    = dm_we;
    s_dm_addr  = dm_addr;
    s_dm_be    = dm_be;
    s_dm_wdata = dm_wdata;
  end

  // monitor: arbitration model plus response scoreboard
  bit          in_tx  = 1'b0;
  int          streak = 0;
  int          len    = 0;
  int          exp_len;
  logic [31:0] g_addr, g_wdata;

  always @(negedge clk) begin
    if (!reset) begin
      in_tx  = 1'b0;
      streak = 0;
    end else begin
      if (mem_req && !in_tx) begin
        bit          gdm;
        logic [31:0] ea;
        chk("grant_has_req", 32'({s_if_req, s_dm_req} != 2'b00), 32'd1);
        gdm = s_dm_req && !(s_if_req && streak == FAIR);
        if (s_dm_req && s_if_req && !gdm) fair_hits++;
        if (gdm) streak = s_if_req ? ((streak < FAIR) ? streak + 1 : FAIR) : 0;
        else     streak = 0;
        ea = gdm ? (s_dm_addr | DOR) : s_if_addr;
        chk("grant_addr", mem_addr, ea);
        chk("grant_we", 32'(mem_we), 32'(gdm && s_dm_we));
        chk("grant_be", 32'(mem_be),
            32'((gdm && s_dm_we) ? s_dm_be : 4'hF));
        if (gdm && s_dm_we) chk("grant_wdata", mem_wdata, s_dm_wdata);
        exp_len = (lat(ea) > TMO) ? TMO : lat(ea);
        g_addr  = mem_addr;
        g_wdata = mem_wdata;
        in_tx   = 1'b1;
        len     = 1;
      end else if (mem_req && in_tx) begin
        len++;
        chk("hold_addr", mem_addr, g_addr);
        chk("hold_wdata", mem_wdata, g_wdata);
      end else if (!mem_req && in_tx) begin
        in_tx = 1'b0;
        chk("busy_len", 32'(len), 32'(exp_len));
      end
      if (if_valid) begin
        chk("if_dm_exclusive", 32'(dm_valid), 32'd0);
        if (if_q.size() == 0) begin
          chk("unexpected_if_valid", 32'(if_valid), 32'd0);
        end else begin
          exp_t e;
          e = if_q.pop_front();
          chk("if_rdata", if_rdata, e.rdata);
          chk("if_bus_err", 32'(bus_err), 32'(e.err));
        end
      end
      if (dm_valid) begin
        if (dm_q.size() == 0) begin
          chk("unexpected_dm_valid", 32'(dm_valid), 32'd0);
        end else begin
          exp_t e;
          e = dm_q.pop_front();
          chk("dm_rdata", dm_rdata, e.rdata);
          chk("dm_bus_err", 32'(bus_err), 32'(e.err));
        end
      end
      if (!if_valid && !dm_valid)
        chk("bus_err_idle", 32'(bus_err), 32'd0);
    end
  end

  initial begin
    reset    = 1'b0;
    if_req   = 1'b0;
    if_addr  = '0;
    dm_req   = 1'b0;
    dm_we    = 1'b0;
    dm_addr  = '0;
    dm_be    = '0;
    dm_wdata = '0;
    mem_rdata = '0;
    mem_ready = 1'b0;
    @(negedge clk);
    chk("rst_ctrl", 32'({if_valid, dm_valid, bus_err, mem_req, mem_we, mem_be}), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_if_rdata", if_rdata, 32'd0);
    @(posedge clk);
    #2 reset = 1'b1;
    run = 1'b1;
    repeat (4000) @(posedge clk);
    run = 1'b0;
    for (int i = 0; i < 200 && (if_req || dm_req); i++) @(posedge clk);
    chk("drain_timeout", 32'({if_req, dm_req}), 32'd0);
    chk("fairness_exercised", 32'(fair_hits != 0), 32'd1);
    repeat (3) @(posedge clk);

    // load in flight, then asynchronous reset abandons it
    #2;
    dm_we   = 1'b0;
    dm_addr = 32'h10;
    dm_be   = 4'h0;
    dm_req  = 1'b1;
    for (int i = 0; i < 20 && !mem_req; i++) @(negedge clk);
    chk("dm_grant_seen", 32'(mem_req), 32'd1);
    chk("dm_region_addr", mem_addr, 32'h8000_0010);
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("async_rst_ctrl", 32'({if_valid, dm_valid, bus_err, mem_req, mem_we, mem_be}), 32'd0);
    chk("async_rst_addr", mem_addr, 32'd0);
    chk("async_rst_dm_rdata", dm_rdata, 32'd0);
    dm_req = 1'b0;
    repeat (3) @(posedge clk);
    #2 reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("no_spurious", 32'({if_valid, dm_valid, mem_req}), 32'd0);
    end

    // fetch at 0x40 never sees ready: timeout after 16 BUSY cycles
    @(posedge clk);
    #2;
    begin
      exp_t e;
      e.rdata = 32'h0;
      e.err   = 1'b1;
      if_q.push_back(e);
    end
    if_addr = 32'h40;
    if_req  = 1'b1;
    for (int i = 0; i < 80 && if_q.size() != 0; i++) @(posedge clk);
    chk("fetch40_done", 32'(if_q.size()), 32'd0);
    repeat (3) @(posedge clk);
    chk("queues_empty", 32'(if_q.size() + dm_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Arbitrates between instruction fetch and data load/store for the CPU's single shared 32-bit memory port.
- Drives one outstanding memory transaction at a time with a req/ready handshake and returns the read data to the requester.
- Data accesses have priority, limited by a fairness counter so fetch cannot starve; a bounded timeout prevents the core deadlocking on a dead bus.
- Sits between the pipeline's fetch/memory stages and the external memory bus.

Parameters:
- DATA_ADDR_OR, 32'h8000_0000, mask OR'd into every data-port address (data region select); fetch addresses pass unmodified.
- FAIRNESS, 4, max consecutive data grants while if_req is pending before fetch is forced; range 1..15.
- TIMEOUT, 16, cycles in BUSY without mem_ready before abort; 0 disables; range 0..255.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- if_req  in  1  fetch request; held with if_addr stable until if_valid.
- if_addr  in  32  fetch byte address.
- if_valid  out  1  one-cycle fetch completion pulse.
- if_rdata  out  32  fetch data, valid with if_valid.
- dm_req  in  1  data request; held with all dm_* inputs stable until dm_valid.
- dm_we  in  1  1 = store, 0 = load.
- dm_addr  in  32  data byte address.
- dm_be  in  4  store byte enables.
- dm_wdata  in  32  store data.
- dm_valid  out  1  one-cycle data completion pulse.
- dm_rdata  out  32  load data, valid with dm_valid; 0 for stores.
- bus_err  out  1  high with if_valid or dm_valid when the transaction timed out.
- mem_req  out  1  memory request.
- mem_we  out  1  memory write enable.
- mem_addr  out  32  memory address.
- mem_be  out  4  memory byte enables; 4'hF for fetch and loads.
- mem_wdata  out  32  memory write data.
- mem_rdata  in  32  memory read data, sampled when mem_ready=1.
- mem_ready  in  1  memory completes the transaction in the current cycle.

Behaviour:
- All outputs are registered. Under reset every output is 0, the state is IDLE and both counters are 0. Reset mid-transaction abandons the transaction with no valid pulse.
- FSM states:
  - IDLE: arbitrate. No request -> stay in IDLE. Grant -> BUSY_IF or BUSY_DM; next cycle mem_req=1 and mem_* carry the granted request's fields.
  - BUSY_IF / BUSY_DM: mem_* held constant.
    - mem_ready=1 -> capture mem_rdata and go to RESP.
    - timeout reached -> drop mem_req and go to RESP with error flagged.
  - RESP: exactly one of if_valid / dm_valid = 1 for one cycle, plus bus_err if flagged; mem_req=0. Then -> IDLE.
- Requester rule: a requester may change its req and address only in the cycle after its valid pulse. IDLE therefore always samples fresh requests.
- Latency: request seen in IDLE at cycle 0; mem_req high at cycle 1; mem_ready at cycle N>=1; valid at cycle N+1. Minimum 3 cycles per transaction, with the next grant at the earliest in the cycle after RESP.
- Arbitration, evaluated in IDLE only:
  - Only one request -> grant it.
  - Both requesting -> grant data unless dm_streak == FAIRNESS, in which case grant fetch.
  - dm_streak increments on a data grant while if_req=1, saturating at FAIRNESS. It clears on any fetch grant, and clears on a data grant when if_req=0.
- Address: data -> mem_addr = dm_addr | DATA_ADDR_OR; fetch -> mem_addr = if_addr. Data-port signals pass unaltered otherwise.
- Stores: mem_we=1, mem_be=dm_be, mem_wdata=dm_wdata; dm_rdata=0 on completion.
- Timeout counter:
  - Cleared on entry to BUSY; increments every BUSY cycle with mem_ready=0.
  - Counter == TIMEOUT-1 with mem_ready=0 -> abort: rdata returned as 0, bus_err=1.
  - mem_ready=1 in the same cycle as the limit -> normal completion (ready wins).
- mem_ready outside BUSY is ignored.

Decomposition:
- Shared package mem_arb_pkg:
  - state enum {IDLE, BUSY_IF, BUSY_DM, RESP};
  - grant enum {GNT_IF, GNT_DM};
  - constant BE_WORD = 4'hF.
- No sub-module; the counters stay inline.

Test Plan:
- Fetch only: if_req=1, if_addr=32'h40, mem_ready at 2nd BUSY cycle returning 32'h00500093 -> mem_addr=32'h40, mem_be=4'hF; if_valid 1 cycle with if_rdata=32'h00500093; bus_err=0.
- Simultaneous requests: if_req=1 and dm_req=1 (load, dm_addr=32'h10) -> data granted first with mem_addr=32'h8000_0010; fetch granted next.
- Fairness: dm_req held continuously with fresh loads, if_req=1, FAIRNESS=4 -> grant order D,D,D,D,I,D.
- Store: dm_we=1, dm_be=4'b0011, dm_wdata=32'hDEADBEEF -> mem_we=1, mem_be=4'b0011, mem_wdata held until mem_ready; dm_valid with dm_rdata=0.
- Timeout: TIMEOUT=16, mem_ready never asserted -> mem_req high exactly 16 cycles, then if_valid=1, bus_err=1, if_rdata=0; mem_ready=1 on the 16th cycle instead -> normal completion, bus_err=0.
- Reset mid-transaction: reset low while in BUSY_DM -> mem_req, dm_valid and all other outputs 0 immediately (asynchronous); after release, IDLE with no spurious valid.
